// File: rtl/control_unit_pkg.sv
// Shared instruction-set definitions for the 8-bit core: opcodes, sequencer states and
// writeback-source encodings. Also imported by the decoder.
package control_unit_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    localparam logic [3:0] OpNop = 4'd0;
    localparam logic [3:0] OpAdd = 4'd1;
    localparam logic [3:0] OpSub = 4'd2;
    localparam logic [3:0] OpAnd = 4'd3;
    localparam logic [3:0] OpOr  = 4'd4;
    localparam logic [3:0] OpXor = 4'd5;
    localparam logic [3:0] OpLdi = 4'd6;
    localparam logic [3:0] OpLd  = 4'd7;
    localparam logic [3:0] OpSt  = 4'd8;
    localparam logic [3:0] OpJmp = 4'd9;
    localparam logic [3:0] OpBeq = 4'd10;
    localparam logic [3:0] OpHlt = 4'd15;

    localparam logic [1:0] WbAlu = 2'd0;
    localparam logic [1:0] WbImm = 2'd1;
    localparam logic [1:0] WbMem = 2'd2;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OpAdd) && (op <= OpXor);
    endfunction

endpackage

// File: rtl/control_unit_pc.sv
// Program counter: loads RESET_PC on reset, increments with wrap, or loads a branch target.
module ctrl_pc #(
    parameter int unsigned    PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic            load_i,
    input  logic [PC_W-1:0] load_val_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: fetch, decode, execute, memory, writeback. Defining
// CTRL_BUS_TIMEOUT_EN adds a bus-ack watchdog that halts the core with fault set.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int unsigned     PC_W           = 8,
    parameter logic [PC_W-1:0] RESET_PC       = 8'h00,
    parameter int unsigned     TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     instr_out,
    input  logic [3:0]      opcode_in,
    input  logic [7:0]      immediate_in,
    input  logic            alu_zero,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            reg_we,
    output logic [1:0]      wb_sel,
    output logic            halted,
    output logic            fault
);

    if (TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e      state_q;
    logic [15:0] ir_q;
    logic        imem_req_q, dmem_req_q, dmem_we_q, reg_we_q, halted_q;
    logic [1:0]  wb_sel_q;
    logic        timeout;
    logic        pc_inc, pc_load;
    logic [PC_W-1:0] pc;

    assign pc_inc  = (state_q == StFetch) && imem_req_q && imem_ack && !timeout;
    assign pc_load = (state_q == StExec) &&
                     ((opcode_in == OpJmp) || ((opcode_in == OpBeq) && alu_zero));

    ctrl_pc #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i      (clk),
        .rst_i      (rst),
        .inc_i      (pc_inc),
        .load_i     (pc_load),
        .load_val_i (PC_W'(immediate_in)),
        .pc_o       (pc)
    );

`ifdef CTRL_BUS_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] wait_q;
    logic            waiting, fault_q;

    assign waiting = ((state_q == StFetch) && imem_req_q && !imem_ack) ||
                     ((state_q == StMem) && dmem_req_q && !dmem_ack);
    assign timeout = waiting && (wait_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            wait_q <= (waiting && !timeout) ? wait_q + CntW'(1) : '0;
            if (timeout) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign fault = fault_q;
`else
    assign timeout = 1'b0;
    assign fault   = 1'b0;
`endif

    // Outputs are registered, so each strobe is set on the edge entering the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFetch;
            ir_q       <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            reg_we_q   <= 1'b0;
            wb_sel_q   <= WbAlu;
            halted_q   <= 1'b0;
        end else begin
            reg_we_q <= 1'b0;
            wb_sel_q <= WbAlu;
            case (state_q)
                StFetch: begin
                    if (timeout) begin
                        imem_req_q <= 1'b0;
                        halted_q   <= 1'b1;
                        state_q    <= StHalt;
                    end else if (imem_req_q && imem_ack) begin
                        ir_q       <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= StDecode;
                    end else begin
                        imem_req_q <= 1'b1;
                    end
                end
                StDecode: begin
                    // Decoder output is already valid here; the write pulse lands in EXEC.
                    if (is_alu_op(opcode_in)) begin
                        reg_we_q <= 1'b1;
                        wb_sel_q <= WbAlu;
                    end else if (opcode_in == OpLdi) begin
                        reg_we_q <= 1'b1;
                        wb_sel_q <= WbImm;
                    end
                    state_q <= StExec;
                end
                StExec: begin
                    if ((opcode_in == OpLd) || (opcode_in == OpSt)) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= (opcode_in == OpSt);
                        state_q    <= StMem;
                    end else if (opcode_in == OpHlt) begin
                        halted_q <= 1'b1;
                        state_q  <= StHalt;
                    end else begin
                        imem_req_q <= 1'b1;
                        state_q    <= StFetch;
                    end
                end
                StMem: begin
                    if (timeout) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        halted_q   <= 1'b1;
                        state_q    <= StHalt;
                    end else if (dmem_req_q && dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (dmem_we_q) begin
                            imem_req_q <= 1'b1;
                            state_q    <= StFetch;
                        end else begin
                            reg_we_q <= 1'b1;
                            wb_sel_q <= WbMem;
                            state_q  <= StWb;
                        end
                    end
                end
                StWb: begin
                    imem_req_q <= 1'b1;
                    state_q    <= StFetch;
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: begin
                    state_q <= StFetch;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc;
    assign instr_out = ir_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign reg_we    = reg_we_q;
    assign wb_sel    = wb_sel_q;
    assign halted    = halted_q;

endmodule
